// File: rtl/ac_store_buffer_if.sv
// rtl/ac_store_buffer_if.sv - store buffer signal bundle; fwd_* present only with STORE_FORWARD_EN
interface ac_store_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ack;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;
`ifdef STORE_FORWARD_EN
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Core/memory side: issues stores, acknowledges writes, performs lookups
  modport master (
    output st_valid, st_addr, st_data, mem_ack,
`ifdef STORE_FORWARD_EN
    output fwd_addr,
    input  fwd_hit, fwd_data,
`endif
    input  st_ready, mem_addr, mem_wdata, mem_we, sb_empty, sb_count
  );

  // Store buffer side
  modport slave (
    input  st_valid, st_addr, st_data, mem_ack,
`ifdef STORE_FORWARD_EN
    input  fwd_addr,
    output fwd_hit, fwd_data,
`endif
    output st_ready, mem_addr, mem_wdata, mem_we, sb_empty, sb_count
  );
endinterface

// File: rtl/ac_store_buffer.sv
// rtl/ac_store_buffer.sv - in-order AC store FIFO draining to data memory; optional STORE_FORWARD_EN lookup
module ac_store_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ac_store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              st_ready;
  logic              push;
  logic              pop;

  // Full is judged from the occupancy count so wrapped pointers never alias full/empty
  assign st_ready     = (count_q < CNT_W'(DEPTH));
  assign push         = sb.st_valid & st_ready;
  assign sb.st_ready  = st_ready;
  assign sb.sb_count  = count_q;
  assign sb.sb_empty  = (count_q == '0);
  assign sb.mem_addr  = mem_addr_q;
  assign sb.mem_wdata = mem_wdata_q;
  assign sb.mem_we    = mem_we_q;

  // Entry storage; contents are qualified by count_q so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= sb.st_addr;
      data_mem[wr_ptr_q] <= sb.st_data;
    end
  end

  // Pointers and occupancy; the in-flight head is only released by pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Drain FSM state and registered memory-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Next state: load head when idle and non-empty, hold the write until ack, then bubble
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_addr_d  = addr_mem[rd_ptr_q];
          mem_wdata_d = data_mem[rd_ptr_q];
          mem_we_d    = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (sb.mem_ack) begin
          pop      = 1'b1;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STORE_FORWARD_EN
  logic [PTR_W-1:0]  fwd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign sb.fwd_hit  = fwd_hit;
  assign sb.fwd_data = fwd_data;

  // Scan oldest to youngest so the youngest matching held entry wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[fwd_idx] == sb.fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`endif
endmodule

// File: tb/tb_ac_store_buffer.sv
// tb/tb_ac_store_buffer.sv - self-checking bench for ac_store_buffer with queue reference model
module tb_ac_store_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  store_t            exp_q[$];
  logic [DATA_W-1:0] wdata_log[$];
  logic              prev_we = 1'b0;
  logic              prev_ack = 1'b0;
  store_t            prev_w;

  always #5 clk = ~clk;

  ac_store_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) sb_bus ();

  ac_store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb_bus)
  );

  // Reference model: held stores in acceptance order; checked mid-cycle, then advanced for the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_we  = 1'b0;
      prev_ack = 1'b0;
    end else begin
      vectors++;
      if (sb_bus.sb_count !== CNT_W'(exp_q.size())) begin
        miscompares++;
        $display("FAIL model_count: got %0d expected %0d", sb_bus.sb_count, exp_q.size());
      end
      vectors++;
      if (sb_bus.st_ready !== (exp_q.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL model_ready: got %0b expected %0b", sb_bus.st_ready, exp_q.size() < DEPTH);
      end
      vectors++;
      if (sb_bus.sb_empty !== (exp_q.size() == 0)) begin
        miscompares++;
        $display("FAIL model_empty: got %0b expected %0b", sb_bus.sb_empty, exp_q.size() == 0);
      end
      if (prev_we && !prev_ack) begin
        vectors++;
        if (sb_bus.mem_we !== 1'b1 || {sb_bus.mem_addr, sb_bus.mem_wdata} !== prev_w) begin
          miscompares++;
          $display("FAIL write_hold: got we=%0b %0h expected we=1 %0h",
                   sb_bus.mem_we, {sb_bus.mem_addr, sb_bus.mem_wdata}, prev_w);
        end
      end
      if (sb_bus.mem_we === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_spurious: got we=1 expected we=0 (model empty)");
        end else if ({sb_bus.mem_addr, sb_bus.mem_wdata} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL write_order: got %0h expected %0h", {sb_bus.mem_addr, sb_bus.mem_wdata}, exp_q[0]);
        end
      end
      prev_we  = sb_bus.mem_we;
      prev_ack = sb_bus.mem_ack;
      prev_w   = {sb_bus.mem_addr, sb_bus.mem_wdata};
      if (sb_bus.mem_we === 1'b1 && sb_bus.mem_ack === 1'b1 && exp_q.size() > 0) begin
        wdata_log.push_back(sb_bus.mem_wdata);
        void'(exp_q.pop_front());
      end
      if (sb_bus.st_valid === 1'b1 && sb_bus.st_ready === 1'b1)
        exp_q.push_back({sb_bus.st_addr, sb_bus.st_data});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int budget = 200;
    while (sb_bus.sb_empty !== 1'b1 && budget > 0) begin
      sb_bus.mem_ack = sb_bus.mem_we;
      step();
      budget--;
    end
    sb_bus.mem_ack = 1'b0;
    vectors++;
    if (sb_bus.sb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_timeout: got sb_empty=%0b expected 1", sb_bus.sb_empty);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step();
    vectors += 6;
    if (sb_bus.sb_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %0b expected 1", sb_bus.sb_empty); end
    if (sb_bus.sb_count !== '0)   begin miscompares++; $display("FAIL reset_count: got %0d expected 0", sb_bus.sb_count); end
    if (sb_bus.st_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b expected 1", sb_bus.st_ready); end
    if (sb_bus.mem_we !== 1'b0)   begin miscompares++; $display("FAIL reset_we: got %0b expected 0", sb_bus.mem_we); end
    if (sb_bus.mem_addr !== '0)   begin miscompares++; $display("FAIL reset_addr: got %0h expected 0", sb_bus.mem_addr); end
    if (sb_bus.mem_wdata !== '0)  begin miscompares++; $display("FAIL reset_wdata: got %0h expected 0", sb_bus.mem_wdata); end
    rst_n = 1'b1;
    step();
    sb_bus.st_valid = 1'b1;
    sb_bus.st_addr  = ADDR_W'($urandom);
    sb_bus.st_data  = DATA_W'($urandom);
    step();
    sb_bus.st_valid = 1'b0;
    step();
    vectors++;
    if (sb_bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL prereset_we: got %0b expected 1", sb_bus.mem_we); end
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (sb_bus.mem_we !== 1'b0)   begin miscompares++; $display("FAIL async_we: got %0b expected 0", sb_bus.mem_we); end
    if (sb_bus.sb_count !== '0)   begin miscompares++; $display("FAIL async_count: got %0d expected 0", sb_bus.sb_count); end
    if (sb_bus.sb_empty !== 1'b1) begin miscompares++; $display("FAIL async_empty: got %0b expected 1", sb_bus.sb_empty); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single;
    sb_bus.st_valid = 1'b1;
    sb_bus.st_addr  = 12'h010;
    sb_bus.st_data  = 16'hBEEF;
    step();
    sb_bus.st_valid = 1'b0;
    vectors += 2;
    if (sb_bus.mem_we !== 1'b0)   begin miscompares++; $display("FAIL single_we_early: got %0b expected 0", sb_bus.mem_we); end
    if (sb_bus.sb_count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", sb_bus.sb_count); end
    step();
    vectors += 3;
    if (sb_bus.mem_we !== 1'b1)       begin miscompares++; $display("FAIL single_we: got %0b expected 1", sb_bus.mem_we); end
    if (sb_bus.mem_addr !== 12'h010)  begin miscompares++; $display("FAIL single_addr: got %0h expected 010", sb_bus.mem_addr); end
    if (sb_bus.mem_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL single_data: got %0h expected beef", sb_bus.mem_wdata); end
    sb_bus.mem_ack = 1'b1;
    step();
    sb_bus.mem_ack = 1'b0;
    vectors += 2;
    if (sb_bus.mem_we !== 1'b0)   begin miscompares++; $display("FAIL single_we_done: got %0b expected 0", sb_bus.mem_we); end
    if (sb_bus.sb_empty !== 1'b1) begin miscompares++; $display("FAIL single_empty: got %0b expected 1", sb_bus.sb_empty); end
  endtask

  task automatic test_fill;
    int base = wdata_log.size();
    sb_bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb_bus.st_valid = 1'b1;
      sb_bus.st_addr  = ADDR_W'($urandom);
      sb_bus.st_data  = DATA_W'(16'h0100 + k);
      step();
    end
    sb_bus.st_addr = ADDR_W'($urandom);
    sb_bus.st_data = 16'h01FF;
    step();
    vectors += 2;
    if (sb_bus.st_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready: got %0b expected 0", sb_bus.st_ready); end
    if (sb_bus.sb_count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d expected 4", sb_bus.sb_count); end
    sb_bus.mem_ack = 1'b1;
    step();
    sb_bus.mem_ack = 1'b0;
    vectors += 2;
    if (sb_bus.sb_count !== 3'd3) begin miscompares++; $display("FAIL fill_pop_count: got %0d expected 3", sb_bus.sb_count); end
    if (sb_bus.st_ready !== 1'b1) begin miscompares++; $display("FAIL fill_pop_ready: got %0b expected 1", sb_bus.st_ready); end
    step();
    sb_bus.st_valid = 1'b0;
    vectors++;
    if (sb_bus.sb_count !== 3'd4) begin miscompares++; $display("FAIL fill_fifth: got %0d expected 4", sb_bus.sb_count); end
    drain();
    vectors++;
    if (wdata_log.size() != base + 5 || wdata_log[wdata_log.size()-1] !== 16'h01FF) begin
      miscompares++;
      $display("FAIL fill_last: got %0d writes expected %0d ending in 01ff", wdata_log.size() - base, 5);
    end
  endtask

  task automatic test_order;
    int base = wdata_log.size();
    fork
      begin : producer
        for (int i = 1; i <= 10; i++) begin
          int wait_budget = 40;
          sb_bus.st_valid = 1'b1;
          sb_bus.st_addr  = ADDR_W'($urandom);
          sb_bus.st_data  = DATA_W'(i);
          while (sb_bus.st_ready !== 1'b1 && wait_budget > 0) begin
            step();
            wait_budget--;
          end
          step();
        end
        sb_bus.st_valid = 1'b0;
      end
      begin : responder
        int n = 0;
        int budget = 400;
        while (n < 10 && budget > 0) begin
          step();
          budget--;
          if (sb_bus.mem_we === 1'b1) begin
            repeat ($urandom_range(0, 3)) step();
            sb_bus.mem_ack = 1'b1;
            step();
            sb_bus.mem_ack = 1'b0;
            n++;
          end
        end
        vectors++;
        if (n != 10) begin miscompares++; $display("FAIL order_timeout: got %0d acks expected 10", n); end
      end
    join
    drain();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (base + i >= wdata_log.size()) begin
        miscompares++;
        $display("FAIL order_missing: got no write %0d expected data %0d", i, i + 1);
      end else if (wdata_log[base+i] !== DATA_W'(i + 1)) begin
        miscompares++;
        $display("FAIL order_data: got %0d expected %0d", wdata_log[base+i], i + 1);
      end
    end
  endtask

  task automatic test_simultaneous;
    sb_bus.mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb_bus.st_valid = 1'b1;
      sb_bus.st_addr  = ADDR_W'($urandom);
      sb_bus.st_data  = DATA_W'($urandom);
      step();
    end
    sb_bus.st_valid = 1'b0;
    vectors += 2;
    if (sb_bus.mem_we !== 1'b1)   begin miscompares++; $display("FAIL simul_pre_we: got %0b expected 1", sb_bus.mem_we); end
    if (sb_bus.sb_count !== 3'd2) begin miscompares++; $display("FAIL simul_pre_count: got %0d expected 2", sb_bus.sb_count); end
    sb_bus.st_valid = 1'b1;
    sb_bus.st_addr  = ADDR_W'($urandom);
    sb_bus.st_data  = DATA_W'($urandom);
    sb_bus.mem_ack  = 1'b1;
    step();
    sb_bus.st_valid = 1'b0;
    sb_bus.mem_ack  = 1'b0;
    vectors += 2;
    if (sb_bus.sb_count !== 3'd2) begin miscompares++; $display("FAIL simul_count: got %0d expected 2", sb_bus.sb_count); end
    if (sb_bus.mem_we !== 1'b0)   begin miscompares++; $display("FAIL simul_bubble: got %0b expected 0", sb_bus.mem_we); end
    sb_bus.mem_ack = 1'b1;
    step();
    sb_bus.mem_ack = 1'b0;
    vectors += 2;
    if (sb_bus.sb_count !== 3'd2) begin miscompares++; $display("FAIL stale_ack_count: got %0d expected 2", sb_bus.sb_count); end
    if (sb_bus.mem_we !== 1'b1)   begin miscompares++; $display("FAIL stale_ack_we: got %0b expected 1", sb_bus.mem_we); end
    drain();
  endtask

`ifdef STORE_FORWARD_EN
  task automatic test_forward;
    logic [ADDR_W-1:0] addrs [3];
    logic              exp_hit;
    logic [DATA_W-1:0] exp_data;
    store_t            pushes [3];
    addrs[0] = 12'h020;
    addrs[1] = 12'h021;
    addrs[2] = 12'h030;
    pushes[0] = {12'h020, 16'h1111};
    pushes[1] = {12'h020, 16'h2222};
    pushes[2] = {12'h030, 16'h3333};
    sb_bus.mem_ack  = 1'b0;
    sb_bus.fwd_addr = 12'h020;
    for (int k = 0; k < 3; k++) begin
      sb_bus.st_valid = 1'b1;
      {sb_bus.st_addr, sb_bus.st_data} = pushes[k];
      step();
    end
    sb_bus.st_valid = 1'b0;
    vectors += 2;
    if (sb_bus.fwd_hit !== 1'b1)      begin miscompares++; $display("FAIL fwd_hit: got %0b expected 1", sb_bus.fwd_hit); end
    if (sb_bus.fwd_data !== 16'h2222) begin miscompares++; $display("FAIL fwd_data: got %0h expected 2222", sb_bus.fwd_data); end
    sb_bus.fwd_addr = 12'h021;
    #1;
    vectors += 2;
    if (sb_bus.fwd_hit !== 1'b0)  begin miscompares++; $display("FAIL fwd_miss_hit: got %0b expected 0", sb_bus.fwd_hit); end
    if (sb_bus.fwd_data !== '0)   begin miscompares++; $display("FAIL fwd_miss_data: got %0h expected 0", sb_bus.fwd_data); end
    for (int r = 0; r < 12; r++) begin
      if (r == 6) begin
        sb_bus.mem_ack = sb_bus.mem_we;
        step();
        sb_bus.mem_ack = 1'b0;
      end
      sb_bus.fwd_addr = addrs[$urandom_range(0, 2)];
      #1;
      exp_hit  = 1'b0;
      exp_data = '0;
      foreach (exp_q[j]) begin
        if (exp_q[j].addr == sb_bus.fwd_addr) begin
          exp_hit  = 1'b1;
          exp_data = exp_q[j].data;
        end
      end
      vectors++;
      if (sb_bus.fwd_hit !== exp_hit || sb_bus.fwd_data !== exp_data) begin
        miscompares++;
        $display("FAIL fwd_random: addr %0h got %0b/%0h expected %0b/%0h",
                 sb_bus.fwd_addr, sb_bus.fwd_hit, sb_bus.fwd_data, exp_hit, exp_data);
      end
    end
    drain();
  endtask
`endif

  // Overall time bound in case a handshake never completes
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Test sequence
  initial begin
    rst_n           = 1'b0;
    sb_bus.st_valid = 1'b0;
    sb_bus.st_addr  = '0;
    sb_bus.st_data  = '0;
    sb_bus.mem_ack  = 1'b0;
`ifdef STORE_FORWARD_EN
    sb_bus.fwd_addr = '0;
`endif
    test_reset();
    test_single();
    test_fill();
    test_order();
    test_simultaneous();
`ifdef STORE_FORWARD_EN
    test_forward();
`endif
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
